// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the accumulator slice: field widths, special
// encodings, accumulator FSM states and a leading-zero helper for the adder.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int FP_BIAS = 127;

    localparam logic [31:0]      FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0]      FP_QNAN     = 32'h7FFF_FFFF;
    localparam logic [EXP_W-1:0] FP_EXP_MAX  = 8'hFF;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_ACC   = 1'b1
    } acc_state_t;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_MAX) && (x[MAN_W-1:0] != '0);
    endfunction

    // Returns 27 for an all-zero input; callers treat zero separately.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Stream bus of the FP32 accumulator: partial-product input, group-sum output.
// Optional feature macro: FP_ACC_STATUS_EN adds out_status.
interface fp_accumulator_if
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
);
    // Both directions use valid/ready: a beat moves on a rising clk edge where
    // valid & ready are both high; valid never waits on ready, and the payload
    // holds steady while valid is high and ready is low.
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
`ifdef FP_ACC_STATUS_EN
    logic [1:0]       out_status;
`endif
    acc_state_t       dbg_state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count,
`ifdef FP_ACC_STATUS_EN
        input  out_status,
`endif
        input  dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count,
`ifdef FP_ACC_STATUS_EN
        output out_status,
`endif
        output dbg_state
    );

endinterface

// File: rtl/fp_adder_v2.sv
// Combinational FP32 adder: round-to-nearest-even, subnormal inputs, flush of
// tiny results to signed zero. FP_ACC_STATUS_EN adds the o_nan/o_ovf flags.
module fp_adder_v2
    import fp_pkg::*;
#(
    parameter int BIAS = FP_BIAS
) (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
`ifdef FP_ACC_STATUS_EN
    output logic        o_nan,
    output logic        o_ovf,
`endif
    output logic [31:0] o_sum
);

    localparam logic signed [9:0] EXP_INF = 10'(2 * BIAS + 1);

    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_swap;

    assign {w_sa, w_ea, w_ma} = i_a;
    assign {w_sb, w_eb, w_mb} = i_b;

    assign w_a_nan = (w_ea == FP_EXP_MAX) && (w_ma != '0);
    assign w_b_nan = (w_eb == FP_EXP_MAX) && (w_mb != '0);
    assign w_a_inf = (w_ea == FP_EXP_MAX) && (w_ma == '0);
    assign w_b_inf = (w_eb == FP_EXP_MAX) && (w_mb == '0);
    assign w_swap  = {w_eb, w_mb} > {w_ea, w_ma};

    logic             w_sign_big, w_sign_small;
    logic [EXP_W-1:0] w_eb_eff, w_es_eff, w_diff;
    logic [23:0]      w_sig_big, w_sig_small;

    // Subnormals use exponent 1 with a clear hidden bit.
    always_comb begin
        w_sign_big   = w_swap ? w_sb : w_sa;
        w_sign_small = w_swap ? w_sa : w_sb;
        w_eb_eff     = w_swap ? ((w_eb == '0) ? 8'd1 : w_eb) : ((w_ea == '0) ? 8'd1 : w_ea);
        w_es_eff     = w_swap ? ((w_ea == '0) ? 8'd1 : w_ea) : ((w_eb == '0) ? 8'd1 : w_eb);
        w_sig_big    = w_swap ? {w_eb != '0, w_mb} : {w_ea != '0, w_ma};
        w_sig_small  = w_swap ? {w_ea != '0, w_ma} : {w_eb != '0, w_mb};
        w_diff       = w_eb_eff - w_es_eff;
    end

    logic [49:0]       w_sh;
    logic [26:0]       w_big27, w_small27, w_norm;
    logic [27:0]       w_sum28;
    logic [4:0]        w_lz;
    logic signed [9:0] w_exp, w_exp_rnd;
    logic              w_round_up;
    logic [24:0]       w_rnd;
    logic [22:0]       w_mant;

    // Significands carry guard, round and sticky bits below the LSB.
    always_comb begin
        w_sh      = {w_sig_small, 26'd0} >> w_diff;
        w_small27 = (w_diff > 8'd49) ? {26'd0, |w_sig_small}
                                     : {w_sh[49:24], |w_sh[23:0]};
        w_big27   = {w_sig_big, 3'b000};
        if (w_sign_big ^ w_sign_small) begin
            w_sum28 = {1'b0, w_big27} - {1'b0, w_small27};
        end else begin
            w_sum28 = {1'b0, w_big27} + {1'b0, w_small27};
        end
        w_lz = lzc27(w_sum28[26:0]);
        if (w_sum28[27]) begin
            w_norm = {w_sum28[27:2], w_sum28[1] | w_sum28[0]};
            w_exp  = $signed({2'b00, w_eb_eff}) + 10'sd1;
        end else begin
            w_norm = w_sum28[26:0] << w_lz;
            w_exp  = $signed({2'b00, w_eb_eff}) - $signed({5'd0, w_lz});
        end
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd      = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
        w_exp_rnd  = w_rnd[24] ? (w_exp + 10'sd1) : w_exp;
        w_mant     = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    end

    always_comb begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            o_sum = FP_QNAN;
        end else if (w_a_inf) begin
            o_sum = {w_sa, FP_EXP_MAX, 23'd0};
        end else if (w_b_inf) begin
            o_sum = {w_sb, FP_EXP_MAX, 23'd0};
        end else if (w_sum28 == '0) begin
            // Exact cancellation gives +0 unless both operands are negative.
            o_sum = {w_sa & w_sb, 31'd0};
        end else if (w_exp_rnd >= EXP_INF) begin
            o_sum = {w_sign_big, FP_EXP_MAX, 23'd0};
        end else if (w_exp_rnd <= 10'sd0) begin
            o_sum = {w_sign_big, 31'd0};
        end else begin
            o_sum = {w_sign_big, w_exp_rnd[7:0], w_mant};
        end
    end

`ifdef FP_ACC_STATUS_EN
    assign o_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    assign o_ovf = ~(w_a_nan | w_b_nan | w_a_inf | w_b_inf) &&
                   (o_sum[30:23] == FP_EXP_MAX);
`endif

endmodule

// File: rtl/fp_accumulator.sv
// Streaming FP32 group-sum stage: folds each in_last-framed group in arrival order.
// Optional feature macro: FP_ACC_STATUS_EN adds per-group sticky NaN/overflow status.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int BIAS  = FP_BIAS
) (
    input  logic             clk,
    input  logic             rst,
    fp_accumulator_if.slave  bus
);

    acc_state_t       r_state;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [CNT_W-1:0] r_out_count;

    logic             w_in_ready;
    logic             w_accept;
    logic [31:0]      w_add_sum;
    logic [CNT_W-1:0] w_cnt_inc;

    // Result register may drain and refill in the same cycle.
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef FP_ACC_STATUS_EN
    logic       w_add_nan, w_add_ovf;
    logic [1:0] w_add_flags, w_beat_flags;
    logic [1:0] r_sticky, r_out_status;

    assign w_add_flags  = {w_add_ovf, w_add_nan};
    assign w_beat_flags = {1'b0, fp_is_nan(bus.in_data)};
`endif

    fp_adder_v2 #(
        .BIAS (BIAS)
    ) u_adder (
        .i_a   (r_acc),
        .i_b   (bus.in_data),
`ifdef FP_ACC_STATUS_EN
        .o_nan (w_add_nan),
        .o_ovf (w_add_ovf),
`endif
        .o_sum (w_add_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_FIRST;
            r_acc       <= FP_POS_ZERO;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= FP_POS_ZERO;
            r_out_count <= '0;
`ifdef FP_ACC_STATUS_EN
            r_sticky     <= 2'b00;
            r_out_status <= 2'b00;
`endif
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    // First beat bypasses the adder so -0 and NaN payloads survive.
                    ST_FIRST: begin
                        if (bus.in_last) begin
                            r_out_data  <= bus.in_data;
                            r_out_count <= CNT_W'(1);
                            r_out_valid <= 1'b1;
`ifdef FP_ACC_STATUS_EN
                            r_out_status <= w_beat_flags;
`endif
                        end else begin
                            r_acc   <= bus.in_data;
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_ACC;
`ifdef FP_ACC_STATUS_EN
                            r_sticky <= w_beat_flags;
`endif
                        end
                    end
                    ST_ACC: begin
                        if (bus.in_last) begin
                            r_out_data  <= w_add_sum;
                            r_out_count <= w_cnt_inc;
                            r_out_valid <= 1'b1;
                            r_acc       <= FP_POS_ZERO;
                            r_cnt       <= '0;
                            r_state     <= ST_FIRST;
`ifdef FP_ACC_STATUS_EN
                            r_out_status <= r_sticky | w_add_flags;
                            r_sticky     <= 2'b00;
`endif
                        end else begin
                            r_acc <= w_add_sum;
                            r_cnt <= w_cnt_inc;
`ifdef FP_ACC_STATUS_EN
                            r_sticky <= r_sticky | w_add_flags;
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.dbg_state = r_state;
`ifdef FP_ACC_STATUS_EN
    assign bus.out_status = r_out_status;
`endif

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: directed group sums plus randomized streams checked
// against an exact-integer FP32 reference model. Honors FP_ACC_STATUS_EN.
module tb_fp_accumulator;
    import fp_pkg::*;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam int W     = 2 + CNT_W + 32;
`ifdef FP_ACC_STATUS_EN
    localparam logic [1:0] ST_MASK = 2'b11;
`else
    localparam logic [1:0] ST_MASK = 2'b00;
`endif

    typedef logic signed [299:0] big_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_accumulator_if #(.CNT_W(CNT_W)) bus();

    fp_accumulator #(
        .CNT_W (CNT_W),
        .BIAS  (127)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec;
    int n_err;
    logic [32:0]  stim_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    // ---------------- reference model ----------------
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Exact value in units of 2^-149.
    function automatic big_t to_fixed(input logic [31:0] x);
        big_t m;
        if (x[30:23] == 8'd0) begin
            m = big_t'(x[22:0]);
        end else begin
            m = big_t'({1'b1, x[22:0]});
            m = m <<< (int'(x[30:23]) - 1);
        end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        big_t s, mag, q, rem;
        int p, e;
        logic sg, g, st;
        if (is_nan(a) || is_nan(b)) return 32'h7FFFFFFF;
        if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : 32'h7FFFFFFF;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        s = to_fixed(a) + to_fixed(b);
        if (s == 0) return {a[31] & b[31], 31'd0};
        sg  = (s < 0);
        mag = sg ? -s : s;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e < 1) return {sg, 31'd0};
        q = mag >>> (p - 23);
        g = 1'b0;
        st = 1'b0;
        if (p >= 24) begin
            g   = mag[p-24];
            rem = mag & ((big_t'(1) <<< (p - 24)) - 1);
            st  = (rem != 0);
        end
        if (g && (st || q[0])) q = q + 1;
        if (q[24]) begin
            q = q >>> 1;
            e = e + 1;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        return {sg, 8'(e), q[22:0]};
    endfunction

    function automatic logic [W-1:0] mk(input logic [1:0] st, input int cnt, input logic [31:0] d);
        return {st & ST_MASK, CNT_W'(cnt), d};
    endfunction

    function automatic logic [W-1:0] ref_group(input logic [31:0] beats[$]);
        logic [31:0] acc, r;
        logic nan, ovf;
        int cnt;
        acc = beats[0];
        nan = is_nan(beats[0]);
        ovf = 1'b0;
        for (int i = 1; i < beats.size(); i++) begin
            r = ref_add(acc, beats[i]);
            if (is_nan(beats[i]) || is_nan(r)) nan = 1'b1;
            if (!is_nan(acc) && !is_inf(acc) && !is_nan(beats[i]) && !is_inf(beats[i]) && is_inf(r))
                ovf = 1'b1;
            acc = r;
        end
        cnt = (beats.size() > SAT) ? SAT : beats.size();
        return mk({ovf, nan}, cnt, acc);
    endfunction

    function automatic logic [31:0] rand_fp();
        int k;
        logic s;
        logic [22:0] m;
        k = $urandom_range(0, 19);
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case (k)
            0:       return {s, 31'd0};
            1:       return {s, 8'd0, m};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, m | 23'd1};
            4:       return {s, 8'($urandom_range(250, 254)), m};
            5:       return {s, 8'($urandom_range(1, 3)), m};
            default: return {s, 8'($urandom_range(120, 135)), m};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic beat(input logic [31:0] d, input logic last);
        stim_q.push_back({last, d});
    endtask

    task automatic run_groups(input int rdy_pct, input int vld_pct);
        int idx, need, budget;
        need = 0;
        foreach (stim_q[i]) if (stim_q[i][32]) need++;
        budget = 20 * stim_q.size() + 50;
        idx = 0;
        obs_q.delete();
        while ((idx < stim_q.size() || obs_q.size() < need) && budget > 0) begin
            @(negedge clk);
            if (idx < stim_q.size() && $urandom_range(0, 99) < vld_pct) begin
                bus.in_valid = 1'b1;
                {bus.in_last, bus.in_data} = stim_q[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (bus.out_valid && bus.out_ready) begin
`ifdef FP_ACC_STATUS_EN
                obs_q.push_back({bus.out_status, bus.out_count, bus.out_data});
`else
                obs_q.push_back({2'b00, bus.out_count, bus.out_data});
`endif
            end
            if (bus.in_valid && bus.in_ready) idx++;
            budget--;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        stim_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++;
        if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); end
        n_vec++;
        if (bus.out_count !== '0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", bus.out_count); end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_vec++;
        if (bus.dbg_state !== ST_FIRST) begin n_err++; $display("FAIL reset_state: got %0d want FIRST", bus.dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        exp_q.delete();
        beat(32'h3F800000, 0); beat(32'h40000000, 0); beat(32'h40400000, 1);
        exp_q.push_back(mk(2'b00, 3, 32'h40C00000));
        beat(32'h80000000, 1);
        exp_q.push_back(mk(2'b00, 1, 32'h80000000));
        beat(32'h7F800000, 0); beat(32'hFF800000, 1);
        exp_q.push_back(mk(2'b01, 2, 32'h7FFFFFFF));
        beat(32'h7F7FFFFF, 0); beat(32'h7F7FFFFF, 1);
        exp_q.push_back(mk(2'b10, 2, 32'h7F800000));
        beat(32'h3F800000, 0); beat(32'hBF800000, 1);
        exp_q.push_back(mk(2'b00, 2, 32'h00000000));
        beat(32'h80000000, 0); beat(32'h80000000, 1);
        exp_q.push_back(mk(2'b00, 2, 32'h80000000));
        beat(32'h7FC01234, 1);
        exp_q.push_back(mk(2'b01, 1, 32'h7FC01234));
        run_groups(100, 100);
        n_vec++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL directed_beats: got %0d results want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL directed_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        exp_q.delete();
        for (int i = 0; i < 20; i++) beat(32'h3F800000, i == 19);
        exp_q.push_back(mk(2'b00, SAT, 32'h41A00000));
        for (int i = 0; i < 15; i++) beat(32'h3F800000, i == 14);
        exp_q.push_back(mk(2'b00, 15, 32'h41700000));
        for (int i = 0; i < 16; i++) beat(32'h3F800000, i == 15);
        exp_q.push_back(mk(2'b00, SAT, 32'h41800000));
        run_groups(100, 100);
        n_vec++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL sat_beats: got %0d results want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL sat_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h3F800000; bus.in_last = 1'b1; bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_data = 32'h40000000;
            #1;
            n_vec++;
            if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_hold_ready_%0d: got %b want 0", k, bus.in_ready); end
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F800000) begin
                n_err++; $display("FAIL b2b_hold_data_%0d: got v=%b %h want v=1 3F800000", k, bus.out_valid, bus.out_data);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drain_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40000000 || bus.out_count !== CNT_W'(1)) begin
            n_err++; $display("FAIL b2b_second: got v=%b %h cnt=%0d want v=1 40000000 cnt=1",
                              bus.out_valid, bus.out_data, bus.out_count);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_group();
        exp_q.delete();
        beat(32'h3F800000, 0); beat(32'h3F800000, 0);
        run_groups(100, 100);
        n_vec++;
        if (obs_q.size() !== 0) begin n_err++; $display("FAIL midrst_early: got %0d results want 0", obs_q.size()); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.dbg_state !== ST_FIRST || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_async: got state=%0d v=%b want FIRST v=0", bus.dbg_state, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        beat(32'h40000000, 1);
        exp_q.push_back(mk(2'b00, 1, 32'h40000000));
        run_groups(100, 100);
        n_vec++;
        if (obs_q.size() !== 1) begin
            n_err++; $display("FAIL midrst_beats: got %0d results want 1", obs_q.size());
        end else begin
            n_vec++;
            if (obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL midrst_data: got %h want %h", obs_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_random(input int n_groups, input int rdy_pct, input int vld_pct);
        logic [31:0] g[$];
        int len;
        exp_q.delete();
        for (int n = 0; n < n_groups; n++) begin
            g.delete();
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) g.push_back(rand_fp());
            for (int i = 0; i < len; i++) beat(g[i], i == len - 1);
            exp_q.push_back(ref_group(g));
        end
        run_groups(rdy_pct, vld_pct);
        n_vec++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL random_beats: got %0d results want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_saturation();
        test_back_to_back();
        test_reset_mid_group();
        test_random(60, 70, 80);
        test_random(40, 100, 100);
        test_random(40, 30, 100);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
